// File: rtl/dec_error_locator_fsm.sv
// Hamming decoder error locator: classifies a captured syndrome and, for single
// errors, scans candidate bit positions through a masked comparator.

module dec_comparator_all_options #(
  parameter int SYND_W = 6
) (
  input  logic [SYND_W-1:0] A,
  input  logic [SYND_W-1:0] B,
  input  logic [1:0]        codeword_width,
  output logic              isEqual
);

  logic [SYND_W-1:0] w_mask;

  // Only the low k syndrome bits are meaningful for the selected codeword width.
  always_comb begin
    w_mask = '0;
    case (codeword_width)
      2'b00:   w_mask = ~({SYND_W{1'b1}} << 4);
      2'b01:   w_mask = ~({SYND_W{1'b1}} << 5);
      default: w_mask = {SYND_W{1'b1}};
    endcase
    isEqual = ((A & w_mask) == (B & w_mask));
  end

endmodule

// state    | meaning
// IDLE     | waiting for start, results from last run held
// CLASSIFY | one cycle decision on masked syndrome and parity
// SCAN     | one candidate position compared per cycle
// DONE     | one-cycle done pulse, back to IDLE
module dec_error_locator_fsm #(
  parameter int SYND_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SYND_W-1:0] syndrome,
  input  logic              parity_err,
  input  logic [1:0]        codeword_width,
  output logic              busy,
  output logic              done,
  output logic [1:0]        num_of_errors,
  output logic [SYND_W-1:0] err_pos
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIFY = 2'd1,
    SCAN     = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            r_state;
  logic [SYND_W-1:0] r_synd;
  logic              r_perr;
  logic [1:0]        r_width;
  logic [SYND_W-1:0] r_idx;

  logic [SYND_W-1:0] w_synd_masked;
  logic [SYND_W-1:0] w_last_idx;
  logic              w_is_equal;

  always_comb begin
    w_synd_masked = r_synd;
    w_last_idx    = SYND_W'(31);
    case (r_width)
      2'b00: begin
        w_synd_masked = r_synd & ~({SYND_W{1'b1}} << 4);
        w_last_idx    = SYND_W'(7);
      end
      2'b01: begin
        w_synd_masked = r_synd & ~({SYND_W{1'b1}} << 5);
        w_last_idx    = SYND_W'(15);
      end
      default: begin
        w_synd_masked = r_synd;
        w_last_idx    = SYND_W'(31);
      end
    endcase
  end

  dec_comparator_all_options #(.SYND_W(SYND_W)) u_cmp (
    .A              (r_synd),
    .B              (r_idx),
    .codeword_width (r_width),
    .isEqual        (w_is_equal)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_synd        <= '0;
      r_perr        <= 1'b0;
      r_width       <= 2'b00;
      r_idx         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      num_of_errors <= 2'd0;
      err_pos       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            r_synd        <= syndrome;
            r_perr        <= parity_err;
            r_width       <= codeword_width;
            num_of_errors <= 2'd0;
            err_pos       <= '0;
            busy          <= 1'b1;
            r_state       <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          if (w_synd_masked == '0) begin
            num_of_errors <= r_perr ? 2'd1 : 2'd0;
            err_pos       <= '0;
            busy          <= 1'b0;
            done          <= 1'b1;
            r_state       <= DONE;
          end else if (!r_perr) begin
            num_of_errors <= 2'd2;
            busy          <= 1'b0;
            done          <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_idx   <= SYND_W'(1);
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_is_equal) begin
            err_pos       <= r_idx;
            num_of_errors <= 2'd1;
            busy          <= 1'b0;
            done          <= 1'b1;
            r_state       <= DONE;
          end else if (r_idx == w_last_idx) begin
            // Syndrome points beyond the codeword: treat as uncorrectable.
            err_pos       <= '0;
            num_of_errors <= 2'd2;
            busy          <= 1'b0;
            done          <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_idx <= r_idx + SYND_W'(1);
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_error_locator_fsm.sv
// Bench for dec_error_locator_fsm: directed plan cases plus random cases
// checked against an arithmetic reference model.

module tb_dec_error_locator_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [5:0] syndrome = '0;
  logic       parity_err = 1'b0;
  logic [1:0] codeword_width = 2'b00;
  logic       busy, done;
  logic [1:0] num_of_errors;
  logic [5:0] err_pos;

  int passed = 0;
  int total  = 0;

  dec_error_locator_fsm #(.SYND_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .syndrome       (syndrome),
    .parity_err     (parity_err),
    .codeword_width (codeword_width),
    .busy           (busy),
    .done           (done),
    .num_of_errors  (num_of_errors),
    .err_pos        (err_pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: result and done cycle from the decoding rules directly.
  task automatic model(input logic [1:0] w, input int s, input bit pe,
                       output int n, output int pos, output int lat);
    int k, width, m;
    k     = (w == 2'b00) ? 4 : (w == 2'b01) ? 5 : 6;
    width = 1 << (k - 1 + 2);
    width = (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
    m     = s % (1 << k);
    pos   = 0;
    if (m == 0) begin
      n = pe ? 1 : 0; lat = 2;
    end else if (!pe) begin
      n = 2; lat = 2;
    end else if (m < width) begin
      n = 1; pos = m; lat = m + 2;
    end else begin
      n = 2; lat = width + 1;
    end
  endtask

  // Start at an edge (cycle 0), scramble inputs afterwards, optionally poke start
  // mid-scan, then verify busy, the done cycle and the results.
  task automatic run_case(input string tag, input logic [1:0] w, input logic [5:0] s,
                          input bit pe, input int poke_cycle);
    int n, pos, lat, cyc;
    bit seen;
    model(w, int'(s), pe, n, pos, lat);
    @(negedge clk);
    start = 1'b1; codeword_width = w; syndrome = s; parity_err = pe;
    @(negedge clk);
    start = 1'b0;
    syndrome = 6'($urandom); parity_err = 1'($urandom); codeword_width = 2'($urandom);
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 40 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy !== 1'b1) check({tag, " busy"}, int'(busy), 1);
        start = (cyc == poke_cycle);
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    check({tag, " done_cycle"}, seen ? cyc : -1, lat);
    check({tag, " busy_in_done"}, int'(busy), 0);
    check({tag, " num_of_errors"}, int'(num_of_errors), n);
    check({tag, " err_pos"}, int'(err_pos), pos);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_pulse_len"}, int'(done), 0);
    check({tag, " start_in_done_ignored"}, int'(busy), 0);
    check({tag, " hold_num"}, int'(num_of_errors), n);
    check({tag, " hold_pos"}, int'(err_pos), pos);
  endtask

  initial begin
    int saw_done;
    repeat (2) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset num", int'(num_of_errors), 0);
    check("reset pos", int'(err_pos), 0);
    rst = 1'b1;

    // Reset mid-scan aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; codeword_width = 2'b10; syndrome = 6'd20; parity_err = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("midscan busy", int'(busy), 1);
    rst = 1'b0;
    saw_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst = 1'b1;
    check("rst busy", int'(busy), 0);
    check("rst num", int'(num_of_errors), 0);
    check("rst pos", int'(err_pos), 0);
    repeat (25) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("rst no_done_after", saw_done, 0);

    run_case("clean",     2'b01, 6'd0,        1'b0, 0);
    run_case("single21",  2'b10, 6'd21,       1'b1, 0);
    run_case("mask",      2'b00, 6'b110101,   1'b1, 0);
    run_case("double",    2'b01, 6'd9,        1'b0, 0);
    run_case("paritybit", 2'b01, 6'd0,        1'b1, 0);
    run_case("outrange",  2'b00, 6'd12,       1'b1, 4);
    run_case("last8",     2'b00, 6'd7,        1'b1, 2);
    run_case("last32",    2'b11, 6'd31,       1'b1, 10);
    run_case("out32",     2'b10, 6'd45,       1'b1, 0);
    run_case("out16",     2'b01, 6'd20,       1'b1, 0);
    run_case("pos1",      2'b01, 6'd1,        1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      run_case("rand", 2'($urandom), 6'($urandom), 1'($urandom),
               int'($urandom_range(0, 12)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dec_error_locator_fsm.md
Name: dec_error_locator_fsm

Overview:
- Sequential error-location controller for the Hamming decoder path.
- Takes a captured syndrome, the overall-parity check result and the codeword width. Classifies the word as no-error, single-error or uncorrectable.
- For single errors, walks candidate bit positions through one instance of dec_comparator_all_options, one compare per cycle, until the syndrome matches. Reports the flipped bit position to the correction stage.
- Sits between the syndrome calculator and the bit-flip/correction logic.

Parameters:
- SYND_W, 6, syndrome/position width; fixed to 6 to match the 32-bit codeword case.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-low
- start  input  1  request; accepted only in IDLE
- syndrome  input  SYND_W  syndrome of received word; sampled on accepted start
- parity_err  input  1  overall parity mismatch (1 = odd number of flipped bits); sampled on accepted start
- codeword_width  input  2  00 = 8-bit, 01 = 16-bit, 1x = 32-bit; sampled on accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; result valid
- num_of_errors  output  2  0 = none, 1 = single (correctable), 2 = uncorrectable
- err_pos  output  SYND_W  flipped bit position, valid when num_of_errors==1

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE; busy=0, done=0, num_of_errors=0, err_pos=0; internal registers cleared. Reset mid-scan aborts immediately with no done pulse.
- Width decode: W = 8/16/32 and effective syndrome bits k = 4/5/6 for codeword_width 00/01/1x. The captured syndrome is masked to its low k bits; upper bits are ignored.
- Position map: position 0 is the overall parity bit; positions 1..W-1 are Hamming positions.
- IDLE:
  - busy=0.
  - On start==1: capture syndrome, parity_err and codeword_width; clear num_of_errors and err_pos; go to CLASSIFY.
- CLASSIFY (1 cycle, busy=1):
  - masked syndrome==0 and parity_err==0 -> num_of_errors=0, err_pos=0, go to DONE.
  - masked syndrome==0 and parity_err==1 -> num_of_errors=1, err_pos=0, go to DONE.
  - masked syndrome!=0 and parity_err==0 -> num_of_errors=2, go to DONE.
  - masked syndrome!=0 and parity_err==1 -> idx=1, go to SCAN.
- SCAN (busy=1):
  - Each cycle the comparator is driven with A=captured syndrome, B=idx, codeword_width=captured width.
  - isEqual==1 -> err_pos=idx, num_of_errors=1, go to DONE.
  - isEqual==0 and idx==W-1 -> num_of_errors=2 (syndrome out of range), err_pos=0, go to DONE.
  - Otherwise idx=idx+1. idx never exceeds W-1, so there is no wrap-around.
- DONE (1 cycle):
  - done=1, busy=0; go to IDLE.
  - num_of_errors and err_pos hold until the next accepted start or reset.
- Latency, counting the start-accept edge as cycle 0:
  - Classified cases: done at cycle 2.
  - Single error at position p>=1: done at cycle p+2.
  - Out-of-range syndrome: done at cycle W+1.
- Start while not IDLE (including during the DONE cycle) is ignored and not queued.
- syndrome, parity_err and codeword_width may change freely after capture; results depend only on the captured values.
- Comparator instance is combinational; no other resource sharing.

Test Plan:
- Reset: assert rst=0 for 2 cycles mid-SCAN (32-bit, syndrome=20) -> busy=0, done never pulses, num_of_errors=0, err_pos=0; next start works normally.
- Clean word: width=01, syndrome=0, parity_err=0 -> done at cycle 2, num_of_errors=0, err_pos=0.
- Single error: width=1x, syndrome=6'd21, parity_err=1 -> busy for cycles 1..22, done pulse at cycle 23, num_of_errors=1, err_pos=21.
- Masking: width=00, syndrome=6'b110101 (effective 5), parity_err=1 -> done at cycle 7, err_pos=5.
- Double and parity-bit errors: width=01, syndrome=9, parity_err=0 -> done at cycle 2, num_of_errors=2. Then syndrome=0, parity_err=1 -> num_of_errors=1, err_pos=0.
- Out of range and ignored start: width=00, syndrome=4'd12 (>=W), parity_err=1 -> scans idx 1..7, done at cycle 9, num_of_errors=2. start pulsed during the scan is ignored, and busy stays 1 until cycle 8.
